// File: rtl/vga_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_pkg
//  Description : Shared constants and types for the VGA pmod receiver:
//                640x480@60 timing, pmod bit positions, lock-state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_rx_pkg;

   // 640x480@60 timing, one pixel per clock
   localparam int C_H_TOTAL         = 800;
   localparam int C_H_SYNC          = 96;
   localparam int C_H_START         = 144;
   localparam int C_H_VIS           = 640;
   localparam int C_V_TOTAL         = 525;
   localparam int C_V_SYNC          = 2;
   localparam int C_V_START         = 34;
   localparam int C_V_VIS           = 480;
   localparam int C_SYNC_ACTIVE_LOW = 1;
   localparam int C_LOCK_FRAMES     = 2;

   // Counter widths
   localparam int C_H_CNT_W = 11;
   localparam int C_V_CNT_W = 10;

   // Bit positions within the pmod byte {hsync, B0, G0, R0, vsync, B1, G1, R1}
   localparam int C_PMOD_HS = 7;
   localparam int C_PMOD_B0 = 6;
   localparam int C_PMOD_G0 = 5;
   localparam int C_PMOD_R0 = 4;
   localparam int C_PMOD_VS = 3;
   localparam int C_PMOD_B1 = 2;
   localparam int C_PMOD_G1 = 1;
   localparam int C_PMOD_R1 = 0;

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pmod_receiver_sync_edge_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_tracker
//  Description : Normalises one sync line to active-high and flags its
//                assertion / deassertion edges against the previous sample.
//  Ports       : clk             - pixel clock
//                i_sync          - raw (already registered) sync sample
//                o_active        - sync currently active (normalised)
//                o_assert_edge   - active now, inactive on previous sample
//                o_deassert_edge - inactive now, active on previous sample
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_tracker #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic i_sync,
   output logic o_active,
   output logic o_assert_edge,
   output logic o_deassert_edge
);

   logic w_active;
   logic r_prev;

   assign w_active = i_sync ^ ACTIVE_LOW;

   // Deliberately not reset: the previous-sample register always follows the
   // line, so leaving reset never fabricates an edge from a sync that was
   // already active when reset was applied.
   always_ff @(posedge clk) begin
      r_prev <= w_active;
   end

   assign o_active        = w_active;
   assign o_assert_edge   = w_active & ~r_prev;
   assign o_deassert_edge = ~w_active & r_prev;

endmodule
`default_nettype wire

// File: rtl/vga_pmod_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pmod_receiver
//  Description : Samples the VGA pmod byte, recovers pixel position from the
//                sync edges, checks line/pulse/frame timing, tracks lock and
//                emits decoded visible pixels with coordinates (2 clk latency).
//  Ports       : clk, rst      - pixel clock, synchronous active-high reset
//                pmod[7:0]     - {hsync, B0, G0, R0, vsync, B1, G1, R1}
//                pix_valid     - visible pixel this cycle (only when locked)
//                pix_x, pix_y  - pixel coordinates, 0 when not valid
//                pix_rgb       - {R1,R0,G1,G0,B1,B0}, 0 when not valid
//                frame_start   - pulse with pixel (0,0)
//                locked        - timing lock status
//                err_count     - saturating timing error count
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pmod_receiver
   import vga_rx_pkg::*;
#(
   parameter int H_TOTAL         = C_H_TOTAL,
   parameter int H_SYNC          = C_H_SYNC,
   parameter int H_START         = C_H_START,
   parameter int H_VIS           = C_H_VIS,
   parameter int V_TOTAL         = C_V_TOTAL,
   parameter int V_START         = C_V_START,
   parameter int V_VIS           = C_V_VIS,
   parameter int SYNC_ACTIVE_LOW = C_SYNC_ACTIVE_LOW,
   parameter int LOCK_FRAMES     = C_LOCK_FRAMES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pmod,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic [7:0]  err_count
);

   localparam logic [C_H_CNT_W-1:0] C_H_SAT = '1;
   localparam logic [C_V_CNT_W-1:0] C_V_SAT = '1;

   // ---------------------------------------------------------------- stage 1
   logic [7:0] r_pmod;

   always_ff @(posedge clk) begin
      r_pmod <= pmod;
   end

   logic w_hs_active, w_hs_assert, w_hs_deassert;
   logic w_vs_active, w_vs_assert, w_vs_deassert;

   sync_edge_tracker #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs_tracker (
      .clk             (clk),
      .i_sync          (r_pmod[C_PMOD_HS]),
      .o_active        (w_hs_active),
      .o_assert_edge   (w_hs_assert),
      .o_deassert_edge (w_hs_deassert)
   );

   sync_edge_tracker #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs_tracker (
      .clk             (clk),
      .i_sync          (r_pmod[C_PMOD_VS]),
      .o_active        (w_vs_active),
      .o_assert_edge   (w_vs_assert),
      .o_deassert_edge (w_vs_deassert)
   );

   logic w_unused;
   assign w_unused = &{1'b0, w_hs_active, w_vs_active, w_vs_deassert};

   // ------------------------------------------------------- position tracking
   // r_h_cnt / r_v_cnt hold the position of the previous stage-1 sample;
   // w_h_cur / w_v_cur are the position of the sample now in stage 1, so the
   // line check sees the last count of the line just ended while the pulse
   // check and the visible window see the current sample.
   logic [C_H_CNT_W-1:0] r_h_cnt, w_h_cur;
   logic [C_V_CNT_W-1:0] r_v_cnt, w_v_cur;
   logic                 r_vs_pend, r_line_seen, r_frame_seen;
   logic                 w_v_reset;

   assign w_v_reset = w_hs_assert & (r_vs_pend | w_vs_assert);

   always_comb begin
      w_h_cur = r_h_cnt;
      if (w_hs_assert)
         w_h_cur = '0;
      else if (r_h_cnt != C_H_SAT)
         w_h_cur = r_h_cnt + 1'b1;

      w_v_cur = r_v_cnt;
      if (w_v_reset)
         w_v_cur = '0;
      else if (w_hs_assert && (r_v_cnt != C_V_SAT))
         w_v_cur = r_v_cnt + 1'b1;
   end

   // ----------------------------------------------------------------- checks
   logic w_line_err, w_pulse_err, w_frame_chk, w_frame_good, w_err;

   assign w_line_err   = w_hs_assert & r_line_seen &
                         (r_h_cnt != C_H_CNT_W'(H_TOTAL - 1));
   assign w_pulse_err  = w_hs_deassert & r_line_seen &
                         (w_h_cur != C_H_CNT_W'(H_SYNC));
   assign w_frame_chk  = w_v_reset & r_frame_seen;
   assign w_frame_good = w_frame_chk & (r_v_cnt == C_V_CNT_W'(V_TOTAL - 1));
   assign w_err        = w_line_err | w_pulse_err | (w_frame_chk & ~w_frame_good);

   // ---------------------------------------------------------------- lock FSM
   lock_state_t r_state, w_state_next;
   logic [7:0]  r_good_frames, w_good_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= SEARCH;
         r_good_frames <= '0;
      end else begin
         r_state       <= w_state_next;
         r_good_frames <= w_good_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good_frames;
      case (r_state)
         SEARCH: begin
            if (w_err) begin
               w_good_next = '0;
            end else if (w_frame_good) begin
               if (r_good_frames + 8'd1 == 8'(LOCK_FRAMES)) begin
                  w_state_next = LOCKED;
                  w_good_next  = '0;
               end else begin
                  w_good_next = r_good_frames + 8'd1;
               end
            end
         end
         LOCKED: begin
            if (w_err) begin
               w_state_next = SEARCH;
               w_good_next  = '0;
            end
         end
         default: begin
            w_state_next = SEARCH;
            w_good_next  = '0;
         end
      endcase
   end

   // ------------------------------------------------------- pixel decoding
   logic                 w_in_win, w_pix_valid;
   logic [C_H_CNT_W-1:0] w_x_full;
   logic [C_V_CNT_W-1:0] w_y_full;
   logic [5:0]           w_rgb;

   assign w_in_win = (w_h_cur >= C_H_CNT_W'(H_START)) &&
                     (w_h_cur <  C_H_CNT_W'(H_START + H_VIS)) &&
                     (w_v_cur >= C_V_CNT_W'(V_START)) &&
                     (w_v_cur <  C_V_CNT_W'(V_START + V_VIS));
   assign w_pix_valid = (r_state == LOCKED) && w_in_win;
   assign w_x_full    = w_h_cur - C_H_CNT_W'(H_START);
   assign w_y_full    = w_v_cur - C_V_CNT_W'(V_START);
   assign w_rgb       = {r_pmod[C_PMOD_R1], r_pmod[C_PMOD_R0],
                         r_pmod[C_PMOD_G1], r_pmod[C_PMOD_G0],
                         r_pmod[C_PMOD_B1], r_pmod[C_PMOD_B0]};

   // ----------------------------------------------------- stage 2 registers
   logic       r_pix_valid, r_frame_start;
   logic [9:0] r_pix_x, r_pix_y;
   logic [5:0] r_pix_rgb;
   logic [7:0] r_err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_vs_pend     <= 1'b0;
         r_line_seen   <= 1'b0;
         r_frame_seen  <= 1'b0;
         r_err_count   <= '0;
         r_pix_valid   <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_pix_rgb     <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_h_cnt      <= w_h_cur;
         r_v_cnt      <= w_v_cur;
         // a hsync edge always consumes a pending vsync (via w_v_reset)
         if (w_hs_assert)
            r_vs_pend <= 1'b0;
         else if (w_vs_assert)
            r_vs_pend <= 1'b1;
         r_line_seen  <= r_line_seen | w_hs_assert;
         r_frame_seen <= r_frame_seen | w_v_reset;
         if (w_err && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
         r_pix_valid   <= w_pix_valid;
         r_pix_x       <= w_pix_valid ? w_x_full[9:0] : 10'd0;
         r_pix_y       <= w_pix_valid ? w_y_full : 10'd0;
         r_pix_rgb     <= w_pix_valid ? w_rgb : 6'd0;
         r_frame_start <= w_pix_valid && (w_x_full == '0) && (w_y_full == '0);
      end
   end

   assign pix_valid   = r_pix_valid;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign pix_rgb     = r_pix_rgb;
   assign frame_start = r_frame_start;
   assign locked      = (r_state == LOCKED);
   assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_pmod_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pmod_receiver
//  Description : Self-checking bench for vga_pmod_receiver. Drives a reduced
//                raster (48x32 totals) with injected timing faults into a
//                negative-sync and a positive-sync instance, both compared
//                every cycle against a timestamp-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pmod_receiver;

   localparam int HT  = 48;
   localparam int HS  = 6;
   localparam int HST = 10;
   localparam int HV  = 32;
   localparam int VT  = 32;
   localparam int VST = 5;
   localparam int VV  = 24;
   localparam int VSW = 2;
   localparam int LF  = 2;

   logic       clk;
   logic       rst;
   logic [7:0] pmod_n, pmod_p;

   logic       pv_n, fs_n, lk_n, pv_p, fs_p, lk_p;
   logic [9:0] x_n, y_n, x_p, y_p;
   logic [5:0] rgb_n, rgb_p;
   logic [7:0] err_n, err_p;

   vga_pmod_receiver #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_VIS(HV),
      .V_TOTAL(VT), .V_START(VST), .V_VIS(VV),
      .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF)
   ) dut_n (
      .clk(clk), .rst(rst), .pmod(pmod_n),
      .pix_valid(pv_n), .pix_x(x_n), .pix_y(y_n), .pix_rgb(rgb_n),
      .frame_start(fs_n), .locked(lk_n), .err_count(err_n)
   );

   vga_pmod_receiver #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_VIS(HV),
      .V_TOTAL(VT), .V_START(VST), .V_VIS(VV),
      .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(LF)
   ) dut_p (
      .clk(clk), .rst(rst), .pmod(pmod_p),
      .pix_valid(pv_p), .pix_x(x_p), .pix_y(y_p), .pix_rgb(rgb_p),
      .frame_start(fs_p), .locked(lk_p), .err_count(err_p)
   );

   logic [36:0] vec_n, vec_p;
   assign vec_n = {pv_n, x_n, y_n, rgb_n, fs_n, lk_n, err_n};
   assign vec_p = {pv_p, x_p, y_p, rgb_p, fs_p, lk_p, err_p};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // behavioural model state: horizontal position is time since the last
   // hsync assertion (or reset); vertical position is hsync edges counted
   // since the frame edge.
   int m_cyc = 0, m_hbase = 0, m_lines = 0, m_good = 0, m_err = 0;
   bit m_line_seen = 0, m_vpend = 0, m_frame_seen = 0, m_locked = 0;

   logic [7:0] p_s1 = 8'h88, p_s0 = 8'h88;
   int         fs_cnt = 0, pv_cnt = 0;
   logic [5:0] rgb_1020 = 6'd0;
   bit         seen_1020 = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mk(input bit hs, input bit vs, input logic [5:0] c);
      return {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
   endfunction

   task automatic model_step(input bit r, input logic [7:0] s1, input logic [7:0] s0,
                             output logic [36:0] e);
      bit ha, hp, va, vp, h_as, h_de, v_as, ev_bad, fgood, lk_prev, pv, fs;
      int h;
      logic [9:0] ex, ey;
      logic [5:0] er;
      if (r) begin
         m_hbase = m_cyc; m_line_seen = 0; m_lines = 0; m_vpend = 0;
         m_frame_seen = 0; m_locked = 0; m_good = 0; m_err = 0;
         e = '0;
      end else begin
         ha = ~s1[7]; hp = ~s0[7]; va = ~s1[3]; vp = ~s0[3];
         h_as = ha && !hp; h_de = !ha && hp; v_as = va && !vp;
         ev_bad = 0; fgood = 0; lk_prev = m_locked;
         if (h_as) begin
            if (m_line_seen && (m_cyc - m_hbase) != HT) ev_bad = 1;
            m_hbase = m_cyc;
            m_line_seen = 1;
         end
         h = m_cyc - m_hbase;
         if (h > 2047) h = 2047;
         if (h_de && m_line_seen && h != HS) ev_bad = 1;
         if (h_as && (m_vpend || v_as)) begin
            if (m_frame_seen) begin
               if (m_lines == VT - 1) fgood = 1; else ev_bad = 1;
            end
            m_lines = 0; m_frame_seen = 1; m_vpend = 0;
         end else if (h_as) begin
            if (m_lines < 1023) m_lines++;
         end else if (v_as) begin
            m_vpend = 1;
         end
         pv = lk_prev && h >= HST && h < HST + HV && m_lines >= VST && m_lines < VST + VV;
         ex = pv ? 10'(h - HST) : 10'd0;
         ey = pv ? 10'(m_lines - VST) : 10'd0;
         er = pv ? {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]} : 6'd0;
         fs = pv && ex == 0 && ey == 0;
         if (ev_bad) begin
            if (m_err < 255) m_err++;
            m_locked = 0; m_good = 0;
         end else if (fgood && !m_locked) begin
            m_good++;
            if (m_good == LF) begin m_locked = 1; m_good = 0; end
         end
         e = {pv, ex, ey, er, fs, m_locked, 8'(m_err)};
      end
      m_cyc++;
   endtask

   task automatic tick(input logic [7:0] p, input bit r);
      logic [36:0] e;
      pmod_n = p;
      pmod_p = p ^ 8'h88;
      rst    = r;
      @(posedge clk);
      model_step(r, p_s1, p_s0, e);
      p_s0 = p_s1;
      p_s1 = p;
      #1;
      chk("cycle_neg", vec_n, e);
      chk("cycle_pos", vec_p, e);
      if (r) chk("reset_zero", vec_n, 0);
      if (pv_n) pv_cnt++;
      if (fs_n) fs_cnt++;
      if (pv_n && x_n == 10 && y_n == 20) begin
         rgb_1020  = rgb_n;
         seen_1020 = 1;
      end
   endtask

   task automatic gen_frame(input int nlines, input int bad_line, input int bad_len,
                            input int bad_pw, input bit xor_mode,
                            input int rst_line, input int rst_hp);
      for (int vp = 0; vp < nlines; vp++) begin
         int len, pw;
         len = (vp == bad_line) ? bad_len : HT;
         pw  = (vp == bad_line) ? bad_pw : HS;
         for (int hp = 0; hp < len; hp++) begin
            int x, y;
            logic [5:0] c;
            x = hp - HST;
            y = vp - VST;
            if (xor_mode && x >= 0 && x < HV && y >= 0 && y < VV) c = 6'(x ^ y);
            else c = 6'($urandom);
            tick(mk(hp < pw, vp < VSW, c), (vp == rst_line) && (hp == rst_hp));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      pmod_n = 8'h88;
      pmod_p = 8'h00;

      for (int i = 0; i < 3; i++) tick(8'h88, 1'b1);
      for (int i = 0; i < 2; i++) tick(8'h88, 1'b0);

      // ideal stream: first frame edge, two clean frames, then locked
      for (int f = 0; f < 4; f++) gen_frame(VT, -1, 0, 0, 1'b1, -1, -1);
      chk("ideal_locked", lk_n, 1);
      chk("ideal_err", err_n, 0);
      chk("ideal_frame_starts", fs_cnt, 2);
      chk("pixel_10_20_seen", seen_1020, 1);
      chk("pixel_10_20_rgb", rgb_1020, 6'h1E);

      // one short line
      gen_frame(VT, $urandom_range(1, VT - 2), HT - 1, HS, 1'b0, -1, -1);
      chk("short_line_err", err_n, 1);
      chk("short_line_unlock", lk_n, 0);
      for (int f = 0; f < 2; f++) gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("short_line_relock", lk_n, 1);

      // one short hsync pulse
      gen_frame(VT, $urandom_range(1, VT - 2), HT, HS - 1, 1'b0, -1, -1);
      chk("short_pulse_err", err_n, 2);
      chk("short_pulse_unlock", lk_n, 0);
      for (int f = 0; f < 2; f++) gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("short_pulse_relock", lk_n, 1);

      // one short frame
      gen_frame(VT - 1, -1, 0, 0, 1'b0, -1, -1);
      pv_cnt = 0;
      for (int f = 0; f < 2; f++) gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("short_frame_err", err_n, 3);
      chk("short_frame_unlock", lk_n, 0);
      chk("short_frame_no_pixels", pv_cnt, 0);
      gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("short_frame_relock", lk_n, 1);

      // reset for one clock in the middle of an hsync pulse while locked
      gen_frame(VT, -1, 0, 0, 1'b0, 10, 2);
      chk("post_reset_err", err_n, 0);
      chk("post_reset_unlocked", lk_n, 0);
      for (int f = 0; f < 2; f++) gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("post_reset_still_search", lk_n, 0);
      gen_frame(VT, -1, 0, 0, 1'b0, -1, -1);
      chk("post_reset_relock", lk_n, 1);
      chk("post_reset_err_after", err_n, 0);

      // 300 malformed lines: error counter saturates
      for (int l = 0; l < 300; l++)
         for (int hp = 0; hp < HT - 1; hp++)
            tick(mk(hp < HS, 1'b0, 6'($urandom)), 1'b0);
      for (int i = 0; i < 4; i++) tick(8'h88, 1'b0);
      chk("err_saturate", err_n, 255);
      chk("err_saturate_pos", err_p, 255);
      chk("saturate_unlocked", lk_n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_pmod_receiver.md
Name: vga_pmod_receiver

Overview:
- Receive-side counterpart of the VGA pmod output: samples the 8-bit pmod byte {hsync, B0, G0, R0, vsync, B1, G1, R1}.
- Recovers horizontal/vertical position from the sync edges, checks 640x480@60 timing, and emits decoded pixels with coordinates.
- Sits in the verification and loopback path. It is used for self-check and frame capture, with one pixel per clk (clk = pixel clock).

Parameters:
H_TOTAL, 800, clocks per line
H_SYNC, 96, hsync pulse width in clocks
H_START, 144, h_cnt of first visible pixel (sync+back porch)
H_VIS, 640, visible pixels per line
V_TOTAL, 525, hsync edges per frame
V_START, 34, v_cnt of first visible line
V_VIS, 480, visible lines
SYNC_ACTIVE_LOW, 1, polarity of both syncs (1 = active when pin is 0)
LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
clk  in  1  clock, one pixel per cycle
rst  in  1  reset, synchronous, active-high
pmod  in  8  {hsync, B0, G0, R0, vsync, B1, G1, R1}
pix_valid  out  1  pix_* hold a visible pixel this cycle
pix_x  out  10  0..H_VIS-1
pix_y  out  10  0..V_VIS-1
pix_rgb  out  6  {R1,R0,G1,G0,B1,B0}
frame_start  out  1  one-cycle pulse with pixel (0,0) when locked
locked  out  1  timing lock status
err_count  out  8  saturating count of timing errors since reset

Behaviour:
- Stage 1: pmod registered unconditionally. Syncs are normalised to active-high via SYNC_ACTIVE_LOW.
- Stage 2: outputs are registered, so pixel data appears 2 clks after the pins.
- Assertion edge = stage-1 sync active while previous stage-1 sync inactive.
- h_cnt (11b):
  - Set to 0 on a hsync assertion edge; otherwise +1.
  - Saturates at 2047, never wraps.
- Line checks:
  - On a hsync assertion edge with line_seen=1, the line is good iff h_cnt == H_TOTAL-1.
  - On the hsync deassertion edge, the pulse is good iff h_cnt == H_SYNC.
  - line_seen is set by the first hsync edge after reset and is cleared by reset. The first edge is never an error.
- Vertical tracking:
  - A vsync assertion edge sets vs_pend.
  - On the next hsync assertion edge, vs_pend clears and v_cnt <= 0. Also on that edge, with frame_seen=1, the frame is good iff v_cnt == V_TOTAL-1. frame_seen is then set.
  - On other hsync assertion edges, v_cnt +1, saturating at 1023.
  - If the vsync and hsync assertion edges coincide, that hsync edge performs the v_cnt reset.
- Error event = any failed line, pulse or frame check. Effects:
  - err_count +1, saturating at 255.
  - The lock FSM goes to SEARCH.
  - Multiple failures in the same cycle count once.
- Lock FSM (states SEARCH, LOCKED):
  - SEARCH: good_frames increments on each good frame check. At LOCK_FRAMES the FSM goes to LOCKED and good_frames clears.
  - Any error event in SEARCH clears good_frames.
  - LOCKED: stays until an error event, which moves it to SEARCH with good_frames=0.
- Visible window: H_START <= h_cnt < H_START+H_VIS and V_START <= v_cnt < V_START+V_VIS.
- pix_valid = LOCKED && window.
  - pix_x = h_cnt - H_START; pix_y = v_cnt - V_START.
  - pix_rgb is decoded from the same stage-1 sample.
  - When pix_valid=0, pix_x, pix_y and pix_rgb are driven 0.
- frame_start = pix_valid && pix_x==0 && pix_y==0.
- Reset values (all outputs and state 0):
  - pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_start=0, locked=0, err_count=0.
  - FSM=SEARCH, good_frames=0, h_cnt=0, v_cnt=0, vs_pend=0, line_seen=0, frame_seen=0.
  - Reset mid-frame gives the same result. Relock requires the first frame edge plus LOCK_FRAMES clean frames.
- Blanked RGB content is ignored and does not affect checks.

Decomposition:
- Package vga_rx_pkg holds:
  - 640x480 timing constants (totals, sync widths, starts, visible sizes).
  - The lock-state enum {SEARCH, LOCKED}.
  - The pmod bit-index constants.
- Sub-module sync_edge_tracker, instantiated twice (hsync, vsync):
  - Polarity normalise, previous-value register.
  - Outputs assert_edge, deassert_edge and active.

Test Plan:
- Ideal 800x525 stream, negative syncs, pixel colour = {x[5:0]^y[5:0]} → locked rises at the first frame check following 2 clean frames after the first frame edge. frame_start pulses once per frame. Pixel (10,20) gives rgb 6'h1E. err_count=0.
- Locked stream; one line of 799 clocks → err_count=1, locked=0 two clks after that hsync edge. Relock after 2 further clean frames.
- hsync pulse of 95 clocks on one line → single error, err_count=1, unlock.
- Frame of 524 lines → err_count=1 at the frame check, unlock. pix_valid stays 0 until relock.
- rst asserted for 1 clk mid-frame while locked → next cycle all outputs 0, locked=0, err_count=0. No error is counted on the first post-reset edges.
- Inject 300 malformed lines → err_count saturates at 255, no wrap. SYNC_ACTIVE_LOW=0 with positive syncs locks identically.
